nibble_serial_adder: RTL and testbench

- Multi-word sequential adder: accepts two NIBBLES*4-bit operands plus a carry-in over a valid/ready handshake.
- Sums them LSB-nibble first, one nibble per clock, by driving an external 4-bit ripple-carry adder instance and consuming its {cout,sum}.
- Carry is held in a register between beats. The registered wide result is presented on a valid/ready output port.
- Sits directly upstream and downstream of the 4-bit adder: feeds its A/B/cin and captures its sum/cout.

---
 rtl/nibble_serial_adder.sv | 115 +++++++++++
 tb/tb_nibble_serial_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-nibble sequential adder: walks two W-bit operands LSB nibble first through an
// external combinational 4-bit adder, holding the carry between beats.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  output logic [3:0]           fa_a,
  output logic [3:0]           fa_b,
  output logic                 fa_cin,
  input  logic [3:0]           fa_sum,
  input  logic                 fa_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout,
  output logic                 busy
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       op_a_q, op_a_d;
  logic [W-1:0]       op_b_q, op_b_d;
  logic [W-1:0]       result_q, result_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W+1:0]   bit_base;

  // Bit offset of the current nibble, i.e. 4*idx.
  assign bit_base = {idx_q, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The adder is combinational, so its result for the nibble driven now is captured here.
        result_d[bit_base +: 4] = fa_sum;
        carry_d                 = fa_cout;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    fa_a      = 4'h0;
    fa_b      = 4'h0;
    fa_cin    = 1'b0;
    if (state_q == S_RUN) begin
      fa_a   = op_a_q[bit_base +: 4];
      fa_b   = op_b_q[bit_base +: 4];
      fa_cin = carry_q;
    end
  end

  // Result registers are left untouched after DONE; out_valid alone qualifies them.
  assign out_sum  = result_q;
  assign out_cout = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder (NIBBLES=4 and NIBBLES=1 builds),
// with the external 4-bit adder modelled behaviourally.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_cin, out_ready;
  logic [15:0] in_a, in_b;
  logic        in_ready, out_valid, out_cout, busy, fa_cin, fa_cout;
  logic [3:0]  fa_a, fa_b, fa_sum;
  logic [15:0] out_sum;

  logic        in_valid1, in_cin1, out_ready1;
  logic [3:0]  in_a1, in_b1;
  logic        in_ready1, out_valid1, out_cout1, busy1, fa_cin1, fa_cout1;
  logic [3:0]  fa_a1, fa_b1, fa_sum1, out_sum1;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  // External ripple-carry adders.
  assign {fa_cout, fa_sum}   = 5'(fa_a)  + 5'(fa_b)  + 5'(fa_cin);
  assign {fa_cout1, fa_sum1} = 5'(fa_a1) + 5'(fa_b1) + 5'(fa_cin1);

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .busy(busy)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_cout(fa_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1), .out_cout(out_cout1),
    .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Carry entering nibble i of a+b+cin, from plain arithmetic on the low 4*i bits.
  function automatic logic carry_into(input int a, input int b, input logic cin, input int i);
    int mask = (1 << (4 * i)) - 1;
    return 1'(((a & mask) + (b & mask) + int'(cin)) >> (4 * i));
  endfunction

  // One full NIBBLES=4 operation; called #1 after a rising edge with the block idle.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input int hold, input logic pulse);
    logic [16:0] exp_sum = 17'(a) + 17'(b) + 17'(cin);
    chk("in_ready_idle", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk("fa_a", fa_a, 32'((a >> (4 * i)) & 16'hF));
      chk("fa_b", fa_b, 32'((b >> (4 * i)) & 16'hF));
      chk("fa_cin", fa_cin, carry_into(a, b, cin, i));
      chk("busy_run", busy, 1);
      chk("in_ready_run", in_ready, 0);
      chk("out_valid_run", out_valid, 0);
      @(posedge clk); #1;
    end
    chk("out_valid_done", out_valid, 1);
    chk("out_sum", out_sum, 32'(exp_sum[15:0]));
    chk("out_cout", out_cout, exp_sum[16]);
    chk("fa_a_done", fa_a, 0);
    for (int h = 0; h < hold; h++) begin
      if (pulse && h == 1) begin
        in_valid = 1'b1; in_a = 16'h0F0F; in_b = 16'h7070; in_cin = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum, 32'(exp_sum[15:0]));
      chk("hold_cout", out_cout, exp_sum[16]);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
    $display("op4 a=%04h b=%04h cin=%0d -> sum=%04h cout=%0d", a, b, cin, out_sum, out_cout);
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] exp_sum = 5'(a) + 5'(b) + 5'(cin);
    chk("n1_in_ready", in_ready1, 1);
    in_a1 = a; in_b1 = b; in_cin1 = cin; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("n1_fa_a", fa_a1, 32'(a));
    chk("n1_fa_b", fa_b1, 32'(b));
    chk("n1_fa_cin", fa_cin1, cin);
    chk("n1_busy", busy1, 1);
    @(posedge clk); #1;
    chk("n1_out_valid", out_valid1, 1);
    chk("n1_out_sum", out_sum1, 32'(exp_sum[3:0]));
    chk("n1_out_cout", out_cout1, exp_sum[4]);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("n1_out_valid_after", out_valid1, 0);
    $display("op1 a=%0h b=%0h cin=%0d -> sum=%0h cout=%0d", a, b, cin, out_sum1, out_cout1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; out_ready = 0;
    in_valid1 = 0; in_a1 = 0; in_b1 = 0; in_cin1 = 0; out_ready1 = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fa_a", fa_a, 0);
    chk("rst_fa_cin", fa_cin, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", in_ready, 1);

    run4(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
    run4(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run4(16'h8000, 16'h8000, 1'b1, 0, 1'b0);
    run4(16'hA5A5, 16'h5A5A, 1'b1, 5, 1'b1);
    run4(16'h0102, 16'h0304, 1'b0, 0, 1'b0);

    // Reset in the middle of RUN, with idx at 2.
    in_a = 16'h9999; in_b = 16'h6666; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_fa_a", fa_a, 32'h9);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_fa_a", fa_a, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_sum", out_sum, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_no_emit", out_valid, 0);
      chk("post_rst_fa_cin", fa_cin, 0);
      @(posedge clk); #1;
    end
    run4(16'h0003, 16'h0004, 1'b0, 0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      run4(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    run1(4'hF, 4'hF, 1'b1);
    run1(4'h0, 4'h0, 1'b0);
    for (int t = 0; t < 8; t++) begin
      run1(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
